// File: rtl/car_alarm_fsm_n.sv
// Parametrised car alarm controller: ARMED / DISARMED / TRIGGERED / ALARM,
// with a shared seconds timer (prescaler + countdown) and a status-LED blinker.
module car_alarm_fsm_n #(
  parameter int N_DOORS     = 2,
  parameter int CLK_PER_SEC = 50000000,
  parameter int TW          = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] doors,
  input  logic [TW-1:0]      t_arm_delay,
  input  logic [TW-1:0]      t_drv_delay,
  input  logic [TW-1:0]      t_pass_delay,
  input  logic [TW-1:0]      t_alarm_on,
  output logic [1:0]         mode,
  output logic               status,
  output logic               siren,
  output logic [N_DOORS-1:0] trig_doors
);

  localparam int PW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_PER_SEC - 1);
  localparam logic [TW-1:0] ONE  = TW'(1);

  localparam logic [1:0] M_ARMED    = 2'b00;
  localparam logic [1:0] M_DISARMED = 2'b01;
  localparam logic [1:0] M_TRIG     = 2'b10;
  localparam logic [1:0] M_ALARM    = 2'b11;

  // DISARMED is split into its four substates so one register holds everything.
  typedef enum logic [2:0] {
    S_ARMED, S_TRIG, S_ALARM, S_D_IGN, S_D_OPEN, S_D_CLOSE, S_D_DELAY
  } state_t;

  state_t          state, state_nxt;
  logic            tmr_run;
  logic [TW-1:0]   tmr_sec;
  logic [PW-1:0]   tmr_pre;
  logic            tmr_exp, tmr_load, tmr_clr;
  logic [TW-1:0]   tmr_val;
  logic            trig_load, trig_clr;
  logic [PW-1:0]   bcnt, bcnt_nxt;
  logic            phase, phase_nxt;
  logic [1:0]      mode_nxt;
  logic            status_nxt;

  // Expiry fires during the last cycle of the last second, so the FSM acts on
  // the edge exactly V*CLK_PER_SEC cycles after the load edge.
  assign tmr_exp = tmr_run && (tmr_sec == ONE) && (tmr_pre == PMAX);

  // Next-state logic and timer/latch commands.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;
    tmr_val   = '0;
    trig_load = 1'b0;
    trig_clr  = 1'b0;
    case (state)
      S_ARMED: begin
        if (ignition) begin
          state_nxt = S_D_IGN;
          tmr_clr   = 1'b1;
        end else if (|doors) begin
          state_nxt = S_TRIG;
          tmr_load  = 1'b1;
          tmr_val   = doors[0] ? t_drv_delay : t_pass_delay;
          trig_load = 1'b1;
        end
      end
      S_TRIG: begin
        if (ignition) begin
          state_nxt = S_D_IGN;
          tmr_clr   = 1'b1;
        end else if (tmr_exp) begin
          state_nxt = S_ALARM;
          tmr_clr   = 1'b1;
        end
      end
      S_ALARM: begin
        if (ignition) begin
          state_nxt = S_D_IGN;
          tmr_clr   = 1'b1;
        end else if (|doors) begin
          tmr_clr   = 1'b1;  // any open door cancels the shut-off count
        end else if (!tmr_run) begin
          tmr_load  = 1'b1;
          tmr_val   = t_alarm_on;
        end else if (tmr_exp) begin
          state_nxt = S_ARMED;
          tmr_clr   = 1'b1;
          trig_clr  = 1'b1;
        end
      end
      S_D_IGN: begin
        if (!ignition) state_nxt = S_D_OPEN;
      end
      S_D_OPEN: begin
        if (ignition)      state_nxt = S_D_IGN;
        else if (doors[0]) state_nxt = S_D_CLOSE;
      end
      S_D_CLOSE: begin
        if (ignition) begin
          state_nxt = S_D_IGN;
        end else if (!doors[0]) begin
          state_nxt = S_D_DELAY;
          tmr_load  = 1'b1;
          tmr_val   = t_arm_delay;
        end
      end
      S_D_DELAY: begin
        if (ignition) begin
          state_nxt = S_D_IGN;
          tmr_clr   = 1'b1;
        end else if (doors[0]) begin
          state_nxt = S_D_CLOSE;
          tmr_clr   = 1'b1;
        end else if (tmr_exp) begin
          state_nxt = S_ARMED;
          tmr_clr   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_ARMED;
        tmr_clr   = 1'b1;
      end
    endcase
  end

  // Blinker runs only while staying in ARMED; any entry restarts it at phase 0.
  always_comb begin
    bcnt_nxt  = '0;
    phase_nxt = 1'b0;
    if (state == S_ARMED && state_nxt == S_ARMED) begin
      if (bcnt == PMAX) begin
        bcnt_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        bcnt_nxt  = bcnt + PW'(1);
        phase_nxt = phase;
      end
    end
  end

  // Output values derived from the next state so the outputs can be registered.
  always_comb begin
    mode_nxt   = M_DISARMED;
    status_nxt = 1'b0;
    case (state_nxt)
      S_ARMED: begin mode_nxt = M_ARMED; status_nxt = phase_nxt; end
      S_TRIG:  begin mode_nxt = M_TRIG;  status_nxt = 1'b1;      end
      S_ALARM: begin mode_nxt = M_ALARM; status_nxt = 1'b1;      end
      default: begin mode_nxt = M_DISARMED; status_nxt = 1'b0;   end
    endcase
  end

  // State, blinker and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_ARMED;
      bcnt       <= '0;
      phase      <= 1'b0;
      mode       <= M_ARMED;
      status     <= 1'b0;
      siren      <= 1'b0;
      trig_doors <= '0;
    end else begin
      state  <= state_nxt;
      bcnt   <= bcnt_nxt;
      phase  <= phase_nxt;
      mode   <= mode_nxt;
      status <= status_nxt;
      siren  <= (state_nxt == S_ALARM);
      if (trig_load)     trig_doors <= doors;
      else if (trig_clr) trig_doors <= '0;
    end
  end

  // Seconds timer: prescaler counts cycles, tmr_sec counts remaining seconds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmr_run <= 1'b0;
      tmr_sec <= '0;
      tmr_pre <= '0;
    end else if (tmr_load) begin
      tmr_run <= 1'b1;
      tmr_sec <= (tmr_val == '0) ? ONE : tmr_val;
      tmr_pre <= '0;
    end else if (tmr_clr) begin
      tmr_run <= 1'b0;
      tmr_sec <= '0;
      tmr_pre <= '0;
    end else if (tmr_run) begin
      if (tmr_pre == PMAX) begin
        tmr_pre <= '0;
        tmr_sec <= tmr_sec - ONE;
        if (tmr_sec == ONE) tmr_run <= 1'b0;
      end else begin
        tmr_pre <= tmr_pre + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_car_alarm_fsm_n.sv
// Bench for car_alarm_fsm_n with CLK_PER_SEC=4, N_DOORS=3, TW=4.
// Table rows hold inputs for n cycles; the expected outputs after the last of
// those edges go through a scoreboard queue and are checked 1 ns after the edge.
module tb_car_alarm_fsm_n;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ignition = 1'b0;
  logic [2:0] doors = 3'b000;
  logic [3:0] t_arm_delay = 4'd0, t_drv_delay = 4'd0, t_pass_delay = 4'd0, t_alarm_on = 4'd0;
  logic [1:0] mode;
  logic       status, siren;
  logic [2:0] trig_doors;

  car_alarm_fsm_n #(.N_DOORS(3), .CLK_PER_SEC(4), .TW(4)) dut (
    .clock(clock), .reset(reset), .ignition(ignition), .doors(doors),
    .t_arm_delay(t_arm_delay), .t_drv_delay(t_drv_delay),
    .t_pass_delay(t_pass_delay), .t_alarm_on(t_alarm_on),
    .mode(mode), .status(status), .siren(siren), .trig_doors(trig_doors)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         nid;
    logic       ign;
    logic [2:0] d;
    int         n;
    logic [1:0] m;
    logic       st, si, tc;
    logic [2:0] tr;
    logic [3:0] ta, td, tp, tl;
  } vec_t;

  typedef struct {
    logic       chk;
    int         nid;
    logic [1:0] m;
    logic       st, si, tc;
    logic [2:0] tr;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  string names[$];
  int    checks = 0;
  int    errors = 0;
  logic [3:0] ca = 4'd2, cd = 4'd1, cp = 4'd2, cl = 4'd3;

  task automatic add(input string nm, input logic ign, input logic [2:0] d, input int n,
                     input logic [1:0] m, input logic st, input logic si,
                     input logic tc, input logic [2:0] tr);
    vec_t v;
    names.push_back(nm);
    v.nid = names.size() - 1;
    v.ign = ign; v.d = d; v.n = n; v.m = m; v.st = st; v.si = si; v.tc = tc; v.tr = tr;
    v.ta = ca; v.td = cd; v.tp = cp; v.tl = cl;
    tbl.push_back(v);
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if (mode !== e.m || status !== e.st || siren !== e.si || (e.tc && trig_doors !== e.tr)) begin
      errors++;
      $display("FAIL %s: got mode=%b status=%b siren=%b trig=%b, want mode=%b status=%b siren=%b trig=%b%s",
               names[e.nid], mode, status, siren, trig_doors, e.m, e.st, e.si, e.tr,
               e.tc ? "" : " (trig unchecked)");
    end
  endtask

  // Called at a negedge; holds inputs for n edges and checks after the last one.
  task automatic drive(input int nid, input logic ign, input logic [2:0] d, input int n,
                       input logic [1:0] m, input logic st, input logic si,
                       input logic tc, input logic [2:0] tr);
    exp_t e, got;
    for (int i = 0; i < n; i++) begin
      ignition = ign;
      doors    = d;
      e.chk = (i == n - 1); e.nid = nid; e.m = m; e.st = st; e.si = si; e.tc = tc; e.tr = tr;
      sb.push_back(e);
      @(posedge clock);
      #1;
      got = sb.pop_front();
      if (got.chk) compare(got);
      @(negedge clock);
    end
  endtask

  task automatic hand(input string nm, input logic ign, input logic [2:0] d, input int n,
                      input logic [1:0] m, input logic st, input logic si,
                      input logic tc, input logic [2:0] tr);
    names.push_back(nm);
    drive(names.size() - 1, ign, d, n, m, st, si, tc, tr);
  endtask

  initial begin
    exp_t r;

    // Test 1: blink after reset, 2 s period, low for the first second.
    add("blink_lo_1to3",   0, 3'b000, 3, 2'b00, 0, 0, 1, 3'b000);
    add("blink_hi_4",      0, 3'b000, 1, 2'b00, 1, 0, 1, 3'b000);
    add("blink_hi_7",      0, 3'b000, 3, 2'b00, 1, 0, 1, 3'b000);
    add("blink_lo_8",      0, 3'b000, 1, 2'b00, 0, 0, 1, 3'b000);
    // Test 2: passenger doors, t_pass=2 -> ALARM 8 cycles after load.
    add("pass_trig",       0, 3'b110, 1, 2'b10, 1, 0, 1, 3'b110);
    add("pass_wait7",      0, 3'b110, 7, 2'b10, 1, 0, 1, 3'b110);
    add("pass_alarm8",     0, 3'b110, 1, 2'b11, 1, 1, 1, 3'b110);
    // Test 4: t_alarm_on=3, reopen cancels, ARMED 12 cycles after final close.
    add("alarm_closed6",   0, 3'b000, 6, 2'b11, 1, 1, 1, 3'b110);
    add("alarm_reopen",    0, 3'b100, 1, 2'b11, 1, 1, 1, 3'b110);
    add("alarm_hold11",    0, 3'b000, 12, 2'b11, 1, 1, 1, 3'b110);
    add("alarm_off12",     0, 3'b000, 1, 2'b00, 0, 0, 1, 3'b000);
    add("rearm_blink_lo",  0, 3'b000, 3, 2'b00, 0, 0, 1, 3'b000);
    add("rearm_blink_hi",  0, 3'b000, 1, 2'b00, 1, 0, 1, 3'b000);
    // Test 3: driver wins, t_drv=1 vs t_pass=5 -> ALARM after 4 cycles.
    cd = 4'd1; cp = 4'd5;
    add("drv_trig",        0, 3'b011, 1, 2'b10, 1, 0, 1, 3'b011);
    add("drv_wait3",       0, 3'b011, 3, 2'b10, 1, 0, 1, 3'b011);
    add("drv_alarm4",      0, 3'b011, 1, 2'b11, 1, 1, 1, 3'b011);
    // Test 6: disarm sequence with restart, passenger doors ignored.
    ca = 4'd2;
    add("alarm_ign_off",   1, 3'b011, 1, 2'b01, 0, 0, 0, 3'b000);
    add("dis_ign_low",     0, 3'b011, 1, 2'b01, 0, 0, 0, 3'b000);
    add("dis_drv_open",    0, 3'b001, 1, 2'b01, 0, 0, 0, 3'b000);
    add("dis_close1",      0, 3'b000, 1, 2'b01, 0, 0, 0, 3'b000);
    add("dis_pass_a",      0, 3'b010, 2, 2'b01, 0, 0, 0, 3'b000);
    add("dis_pass_b",      0, 3'b100, 2, 2'b01, 0, 0, 0, 3'b000);
    add("dis_reopen",      0, 3'b001, 1, 2'b01, 0, 0, 0, 3'b000);
    add("dis_close2",      0, 3'b000, 1, 2'b01, 0, 0, 0, 3'b000);
    add("dis_pass_c",      0, 3'b110, 4, 2'b01, 0, 0, 0, 3'b000);
    add("dis_pass_d",      0, 3'b010, 3, 2'b01, 0, 0, 0, 3'b000);
    add("dis_armed8",      0, 3'b000, 1, 2'b00, 0, 0, 0, 3'b000);
    // Test 5: ignition on the expiry cycle wins.
    cp = 4'd1;
    add("t5_trig",         0, 3'b010, 1, 2'b10, 1, 0, 1, 3'b010);
    add("t5_wait3",        0, 3'b000, 3, 2'b10, 1, 0, 1, 3'b010);
    add("t5_ign_at_exp",   1, 3'b000, 1, 2'b01, 0, 0, 0, 3'b000);
    add("t5_no_siren",     1, 3'b000, 3, 2'b01, 0, 0, 0, 3'b000);
    // Zero delay is treated as one second.
    ca = 4'd0;
    add("z_ign_low",       0, 3'b000, 1, 2'b01, 0, 0, 0, 3'b000);
    add("z_drv_open",      0, 3'b001, 1, 2'b01, 0, 0, 0, 3'b000);
    add("z_close",         0, 3'b000, 1, 2'b01, 0, 0, 0, 3'b000);
    add("z_wait3",         0, 3'b000, 3, 2'b01, 0, 0, 0, 3'b000);
    add("z_armed4",        0, 3'b000, 1, 2'b00, 0, 0, 0, 3'b000);
    // Ignition has priority over doors in ARMED.
    add("armed_ign_prio",  1, 3'b001, 1, 2'b01, 0, 0, 0, 3'b000);

    // Reset state (asynchronous, seen before any release).
    #12;
    names.push_back("reset_state");
    r.chk = 1; r.nid = names.size() - 1; r.m = 2'b00; r.st = 0; r.si = 0; r.tc = 1; r.tr = 3'b000;
    compare(r);

    @(negedge clock);
    reset = 1'b1;
    foreach (tbl[k]) begin
      t_arm_delay  = tbl[k].ta;
      t_drv_delay  = tbl[k].td;
      t_pass_delay = tbl[k].tp;
      t_alarm_on   = tbl[k].tl;
      drive(tbl[k].nid, tbl[k].ign, tbl[k].d, tbl[k].n, tbl[k].m, tbl[k].st, tbl[k].si,
            tbl[k].tc, tbl[k].tr);
    end

    // Reset in the middle of an arm-delay countdown.
    t_arm_delay = 4'd2;
    hand("mid_open",  0, 3'b000, 1, 2'b01, 0, 0, 0, 3'b000);
    hand("mid_drv",   0, 3'b001, 1, 2'b01, 0, 0, 0, 3'b000);
    hand("mid_count", 0, 3'b000, 3, 2'b01, 0, 0, 1, 3'b010);
    #2 reset = 1'b0;
    #1;
    names.push_back("mid_reset_async");
    r.chk = 1; r.nid = names.size() - 1; r.m = 2'b00; r.st = 0; r.si = 0; r.tc = 1; r.tr = 3'b000;
    compare(r);
    @(negedge clock);
    reset = 1'b1;
    hand("post_rst_lo",   0, 3'b000, 3, 2'b00, 0, 0, 1, 3'b000);
    hand("post_rst_hi",   0, 3'b000, 1, 2'b00, 1, 0, 1, 3'b000);
    hand("post_rst_trig", 0, 3'b100, 1, 2'b10, 1, 0, 1, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
